vsub16_seq: RTL and testbench
=============================

// Module: vsub16_seq
// PURPOSE
//  Sequential 16-lane FP16 vector subtractor: DiffV[i] = InvalA[i] - InvalB[i] per 16-bit lane.
//  Companion to the combinational vector adder. Shares one (or a few) lane datapaths, iterating over lanes.
//  Uses a start/busy/done handshake so the vector unit's control FSM can sequence it.
// PARAMETERS
//  NLANES     16  number of FP16 lanes (vector width = 16*NLANES)
//  LPC        1   lanes processed per cycle; must divide NLANES; NGRP = NLANES/LPC
// PORTS
//  clk      in   1            rising-edge clock
//  rst_n    in   1            asynchronous active-low reset
//  start    in   1            operation request; sampled only in IDLE or DONE
//  InvalA   in   16*NLANES    minuend vector; lane i = bits [16i+15:16i]
//  InvalB   in   16*NLANES    subtrahend vector
//  DiffV    out  16*NLANES    registered difference vector
//  Overflw  out  1            sticky OR of per-lane overflow for current op
//  busy     out  1            high in RUN
//  done     out  1            one-cycle pulse; DiffV/Overflw valid and stable from this cycle
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, grp=0, DiffV=0, Overflw=0, busy=0, done=0.
//  FSM IDLE -> RUN on start. RUN -> DONE after group NGRP-1 is written. DONE -> RUN on start, else IDLE.
//  Accepting start (edge E0): capture InvalA/InvalB into operand regs, DiffV=0, Overflw=0, grp=0, busy=1.
//  RUN: at edge E(g+1), lanes g*LPC..g*LPC+LPC-1 are written and grp increments.
//  Latency: done=1 in the cycle after edge E(NGRP) (e.g. NGRP=16: 16 cycles after start is sampled).
//  start in RUN is ignored, with no queueing. Inputs may change after E0 without effect.
//  DiffV and Overflw hold after DONE until the next accepted start.
//  Lane arithmetic is A + (-B), with B's sign bit flipped.
//  - Guard/sticky alignment: 15-bit {ovf,hidden,mant[9:0],g,r,s}. Smaller exponent shifts right; sticky ORs in.
//  - Exp==0 means subnormal: hidden=0, treated as exponent 1 for alignment. No other hidden-bit rules.
//  - Normalize: carry-out shifts right and increments the exponent. Leading zeros shift left, but never below exponent 0.
//  - Round: add the guard bit (round half away from zero). Rounding carry renormalizes.
//  - Exact zero result (equal magnitudes) = 0x0000 (+0).
//  - Either input exponent == 5'h1F: result {sign_of_that_operand,5'h1F,10'h0}, lane ovf=1.
//    The sign of B is flipped; A has priority when both are 1F.
//  - Result exponent reaching 5'h1F: lane ovf=1, result is infinity {sign,5'h1F,10'h0} (see CONFIGURATION).
//  - Overflw |= lane ovf for every lane written.
// CONFIGURATION
//  VSUB_SATURATE_EN defined: lanes that overflow from finite operands return max finite {sign,15'h7BFF}.
//    Inf/NaN inputs still give infinity. Overflw is set as normal.
//  Not defined: overflowing lanes return signed infinity.
// STRUCTURE
//  Package vfp_pkg holds:
//  - FP16_W=16, FP16_EXP_INF=5'h1F, FP16_EXP_MAX=5'h1E, FP16_MAX_FIN=15'h7BFF
//  - state enum {IDLE,RUN,DONE}
//  Sub-module fp16_sub_core: combinational single-lane A-B -> {diff[15:0], ovf}. It is instantiated LPC times.
//  This top level holds FSM, group counter, operand regs, lane mux/demux and sticky overflow.
// TESTING
//  1) All lanes A=0x4200 (3.0), B=0x3C00 -> DiffV lanes all 0x4000, Overflw=0, done exactly 16 cycles after start.
//  2) All lanes A=B=0x5338 -> DiffV all 0x0000 (+0), Overflw=0.
//  3) A=0x3C00, B=0x3C01 all lanes -> 0x9400 (left-normalize, exponent decrement). Also A=0x0200, B=0x0100 -> 0x0100.
//  4) Lane 5 A=0x7BFF, B=0xFBFF; others A=0x3C00, B=0x3800:
//     lane5=0x7C00 (0x7BFF with VSUB_SATURATE_EN), others 0x3800, Overflw=1.
//  5) Lane 0 A=0x7C00, B=0x3C00 -> 0x7C00, Overflw=1 (both configs). Lane 0 A=0x3C00, B=0x7C00 -> 0xFC00.
//  6) Handshake: start pulsed again mid-RUN -> ignored, done still at cycle 16 with the first op's data.
//     rst_n low at cycle 7 -> DiffV/Overflw/busy/done=0 immediately. Next start completes normally.
//     start held high through DONE -> back-to-back op, no idle cycle.

Source files
------------

// File: rtl/vfp_pkg.sv
// Shared FP16 constants and the sequencer state type for the vector subtract unit.
package vfp_pkg;

  localparam int         FP16_W       = 16;
  localparam logic [4:0] FP16_EXP_INF = 5'h1F;
  localparam logic [4:0] FP16_EXP_MAX = 5'h1E;
  localparam logic [14:0] FP16_MAX_FIN = 15'h7BFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } vsub_state_t;

endpackage

// File: rtl/vsub16_seq_if.sv
// Operand/result bus and start/busy/done handshake between the vector control FSM and vsub16_seq.
interface vsub16_seq_if #(
  parameter int NLANES = 16
);

  logic                 start;
  logic [16*NLANES-1:0] InvalA;
  logic [16*NLANES-1:0] InvalB;
  logic [16*NLANES-1:0] DiffV;
  logic                 Overflw;
  logic                 busy;
  logic                 done;

  modport master (
    output start, InvalA, InvalB,
    input  DiffV, Overflw, busy, done
  );

  modport slave (
    input  start, InvalA, InvalB,
    output DiffV, Overflw, busy, done
  );

endinterface

// File: rtl/fp16_sub_core.sv
// Combinational single-lane FP16 a - b with guard/round/sticky alignment and overflow flag.
// Build option: VSUB_SATURATE_EN makes finite overflow return max finite instead of infinity.
module fp16_sub_core
  import vfp_pkg::*;
(
  input  logic [FP16_W-1:0] a,
  input  logic [FP16_W-1:0] b,
  output logic [FP16_W-1:0] diff,
  output logic              ovf
);

  logic        sign_a, sign_b, sign_r, a_big, hid, sticky;
  logic [4:0]  exp_a, exp_b, exp_big, exp_small, shamt;
  logic [14:0] man_a, man_b, man_big, man_small, man_al, lost, sum, nrm;
  logic [6:0]  exp_n;
  logic [11:0] rnd;
  logic [9:0]  frac;

  always_comb begin
    sign_a    = a[15];
    sign_b    = ~b[15];
    exp_a     = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
    exp_b     = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
    man_a     = {1'b0, (a[14:10] != 5'd0), a[9:0], 3'b000};
    man_b     = {1'b0, (b[14:10] != 5'd0), b[9:0], 3'b000};
    // Magnitude order of the raw encodings matches numeric magnitude, so it picks the big operand.
    a_big     = (a[14:0] >= b[14:0]);
    exp_big   = a_big ? exp_a : exp_b;
    exp_small = a_big ? exp_b : exp_a;
    man_big   = a_big ? man_a : man_b;
    man_small = a_big ? man_b : man_a;
    sign_r    = a_big ? sign_a : sign_b;
    shamt     = exp_big - exp_small;

    if (shamt >= 5'd15) begin
      man_al = '0;
      lost   = man_small;
    end else begin
      man_al = man_small >> shamt;
      lost   = man_small & ((15'd1 << shamt) - 15'd1);
    end
    sticky    = |lost;
    man_al[0] = man_al[0] | sticky;

    sum   = (sign_a == sign_b) ? (man_big + man_al) : (man_big - man_al);
    nrm   = sum;
    exp_n = {2'b00, exp_big};
    if (sum[14]) begin
      nrm   = {1'b0, sum[14:2], sum[1] | sum[0]};
      exp_n = exp_n + 7'd1;
    end else begin
      // Stop at exponent 1 so tiny results land in the subnormal range.
      for (int i = 0; i < 13; i++) begin
        if (!nrm[13] && (exp_n > 7'd1)) begin
          nrm   = {nrm[13:0], 1'b0};
          exp_n = exp_n - 7'd1;
        end
      end
    end

    rnd = {1'b0, nrm[13:3]} + {11'd0, nrm[2]};
    if (rnd[11]) begin
      hid   = 1'b1;
      frac  = rnd[10:1];
      exp_n = exp_n + 7'd1;
    end else begin
      hid  = rnd[10];
      frac = rnd[9:0];
    end

    diff = {sign_r, (hid ? exp_n[4:0] : 5'd0), frac};
    ovf  = 1'b0;
    if (sum == 15'd0) begin
      diff = '0;
    end else if (exp_n > {2'b00, FP16_EXP_MAX}) begin
      ovf = 1'b1;
`ifdef VSUB_SATURATE_EN
      diff = {sign_r, FP16_MAX_FIN};
`else
      diff = {sign_r, FP16_EXP_INF, 10'h000};
`endif
    end

    if (a[14:10] == FP16_EXP_INF) begin
      diff = {a[15], FP16_EXP_INF, 10'h000};
      ovf  = 1'b1;
    end else if (b[14:10] == FP16_EXP_INF) begin
      diff = {~b[15], FP16_EXP_INF, 10'h000};
      ovf  = 1'b1;
    end
  end

endmodule

// File: rtl/vsub16_seq.sv
// Sequential FP16 vector subtractor: iterates LPC lanes per cycle through fp16_sub_core.
// Build option: VSUB_SATURATE_EN (see fp16_sub_core) selects saturating overflow.
module vsub16_seq
  import vfp_pkg::*;
#(
  parameter int NLANES = 16,
  parameter int LPC    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  vsub16_seq_if.slave     bus
);

  localparam int NGRP = NLANES / LPC;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int VW   = FP16_W * NLANES;

  vsub_state_t   state, state_nxt;
  logic [GW-1:0] grp;
  logic [VW-1:0] opa, opb, diff_q;
  logic          ovf_q;
  logic          accept, last_grp, busy_c, done_c;

  logic [FP16_W-1:0] lane_a [LPC];
  logic [FP16_W-1:0] lane_b [LPC];
  logic [FP16_W-1:0] lane_d [LPC];
  logic [LPC-1:0]    lane_ovf;

  assign accept   = bus.start && ((state == IDLE) || (state == DONE));
  assign last_grp = (grp == GW'(NGRP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        busy_c = 1'b1;
        if (last_grp) state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = bus.start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int l = 0; l < LPC; l++) begin
      lane_a[l] = opa[(int'(grp) * LPC + l) * FP16_W +: FP16_W];
      lane_b[l] = opb[(int'(grp) * LPC + l) * FP16_W +: FP16_W];
    end
  end

  for (genvar l = 0; l < LPC; l++) begin : g_lane
    fp16_sub_core u_core (
      .a    (lane_a[l]),
      .b    (lane_b[l]),
      .diff (lane_d[l]),
      .ovf  (lane_ovf[l])
    );
  end

  // Results are cleared on accept so a partially written vector never mixes with an old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp    <= '0;
      opa    <= '0;
      opb    <= '0;
      diff_q <= '0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      grp    <= '0;
      opa    <= bus.InvalA;
      opb    <= bus.InvalB;
      diff_q <= '0;
      ovf_q  <= 1'b0;
    end else if (state == RUN) begin
      for (int l = 0; l < LPC; l++) begin
        diff_q[(int'(grp) * LPC + l) * FP16_W +: FP16_W] <= lane_d[l];
      end
      ovf_q <= ovf_q | (|lane_ovf);
      grp   <= last_grp ? '0 : grp + GW'(1);
    end
  end

  assign bus.DiffV   = diff_q;
  assign bus.Overflw = ovf_q;
  assign bus.busy    = busy_c;
  assign bus.done    = done_c;

endmodule

// File: tb/tb_vsub16_seq.sv
// Table-driven scoreboard bench for vsub16_seq plus handshake corner sequences.
module tb_vsub16_seq;

  localparam int NLANES  = 16;
  localparam int VW      = 16 * NLANES;
  localparam int LATENCY = 16;
  localparam int NVEC    = 15;

`ifdef VSUB_SATURATE_EN
  localparam logic [15:0] OVF_POS = 16'h7BFF;
  localparam logic [15:0] OVF_NEG = 16'hFBFF;
`else
  localparam logic [15:0] OVF_POS = 16'h7C00;
  localparam logic [15:0] OVF_NEG = 16'hFC00;
`endif

  typedef struct {
    string       name;
    logic [15:0] base_a;
    logic [15:0] base_b;
    logic [15:0] exp_base;
    int          sp_lane;
    logic [15:0] sp_a;
    logic [15:0] sp_b;
    logic [15:0] exp_sp;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    string         name;
    logic [VW-1:0] diffv;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  vsub16_seq_if #(.NLANES(NLANES)) bus ();

  vsub16_seq #(.NLANES(NLANES), .LPC(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  vec_t vecs[NVEC];
  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input string name, input logic [15:0] ba, input logic [15:0] bb,
                              input logic [15:0] eb, input int sl, input logic [15:0] sa,
                              input logic [15:0] sbv, input logic [15:0] es, input logic eo);
    vec_t v;
    v.name = name; v.base_a = ba; v.base_b = bb; v.exp_base = eb;
    v.sp_lane = sl; v.sp_a = sa; v.sp_b = sbv; v.exp_sp = es; v.exp_ovf = eo;
    return v;
  endfunction

  function automatic exp_t expectOf(input vec_t v);
    exp_t e;
    e.name = v.name;
    e.ovf  = v.exp_ovf;
    e.diffv = '0;
    for (int l = 0; l < NLANES; l++)
      e.diffv[16*l +: 16] = (l == v.sp_lane) ? v.exp_sp : v.exp_base;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic driveVec(input vec_t v);
    for (int l = 0; l < NLANES; l++) begin
      bus.InvalA[16*l +: 16] = (l == v.sp_lane) ? v.sp_a : v.base_a;
      bus.InvalB[16*l +: 16] = (l == v.sp_lane) ? v.sp_b : v.base_b;
    end
  endtask

  task automatic scramble();
    for (int w = 0; w < VW / 32; w++) begin
      bus.InvalA[32*w +: 32] = $urandom();
      bus.InvalB[32*w +: 32] = $urandom();
    end
  endtask

  // Drives one request across edge E0 and records the expected result.
  task automatic applyStimulus(input vec_t v, input bit hold);
    driveVec(v);
    sb_q.push_back(expectOf(v));
    bus.start = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin
      bus.start = 1'b0;
      scramble();
    end
    checkOutput({v.name, "_busy"}, VW'(bus.busy), VW'(1));
  endtask

  task automatic finishOp(input string tag, input int already);
    int   cycles;
    exp_t e;
    cycles = already;
    while (bus.done !== 1'b1 && cycles < LATENCY + 8) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({tag, "_latency"}, VW'(cycles), VW'(LATENCY));
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_scoreboard actual=empty required=entry", tag);
    end else begin
      e = sb_q.pop_front();
      checkOutput({tag, "_DiffV"}, bus.DiffV, e.diffv);
      checkOutput({tag, "_Overflw"}, VW'(bus.Overflw), VW'(e.ovf));
    end
  endtask

  initial begin
    vecs[0]  = mk("sub3m1",    16'h4200, 16'h3C00, 16'h4000, -1, 16'h0, 16'h0, 16'h0, 1'b0);
    vecs[1]  = mk("equal",     16'h5338, 16'h5338, 16'h0000, -1, 16'h0, 16'h0, 16'h0, 1'b0);
    vecs[2]  = mk("lzshift",   16'h3C00, 16'h3C01, 16'h9400, -1, 16'h0, 16'h0, 16'h0, 1'b0);
    vecs[3]  = mk("subnorm",   16'h0200, 16'h0100, 16'h0100, -1, 16'h0, 16'h0, 16'h0, 1'b0);
    vecs[4]  = mk("ovf_l5",    16'h3C00, 16'h3800, 16'h3800, 5, 16'h7BFF, 16'hFBFF, OVF_POS, 1'b1);
    vecs[5]  = mk("inf_a",     16'h3C00, 16'h3800, 16'h3800, 0, 16'h7C00, 16'h3C00, 16'h7C00, 1'b1);
    vecs[6]  = mk("inf_b",     16'h3C00, 16'h3800, 16'h3800, 0, 16'h3C00, 16'h7C00, 16'hFC00, 1'b1);
    vecs[7]  = mk("negb",      16'h3C00, 16'hBC00, 16'h4000, -1, 16'h0, 16'h0, 16'h0, 1'b0);
    vecs[8]  = mk("zero_a",    16'h0000, 16'h3C00, 16'hBC00, -1, 16'h0, 16'h0, 16'h0, 1'b0);
    vecs[9]  = mk("sticky",    16'h3C00, 16'h1400, 16'h3BFE, -1, 16'h0, 16'h0, 16'h0, 1'b0);
    vecs[10] = mk("rnd_half",  16'h3C00, 16'h9000, 16'h3C01, -1, 16'h0, 16'h0, 16'h0, 1'b0);
    vecs[11] = mk("rnd_carry", 16'h3BFF, 16'h8C00, 16'h3C00, -1, 16'h0, 16'h0, 16'h0, 1'b0);
    vecs[12] = mk("sub2norm",  16'h0200, 16'h8200, 16'h0400, -1, 16'h0, 16'h0, 16'h0, 1'b0);
    vecs[13] = mk("ovf_neg",   16'h4200, 16'h3C00, 16'h4000, 15, 16'hFBFF, 16'h7BFF, OVF_NEG, 1'b1);
    vecs[14] = mk("both_inf",  16'h3C00, 16'h3800, 16'h3800, 3, 16'hFC00, 16'hFC00, 16'hFC00, 1'b1);

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.InvalA = '0;
    bus.InvalB = '0;
    #12;
    checkOutput("rst_DiffV",   bus.DiffV, '0);
    checkOutput("rst_Overflw", VW'(bus.Overflw), VW'(0));
    checkOutput("rst_busy",    VW'(bus.busy), VW'(0));
    checkOutput("rst_done",    VW'(bus.done), VW'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      exp_t held;
      held = expectOf(vecs[i]);
      applyStimulus(vecs[i], 1'b0);
      finishOp(vecs[i].name, 0);
      @(posedge clk); #1;
      checkOutput({vecs[i].name, "_done_pulse"}, VW'(bus.done), VW'(0));
      checkOutput({vecs[i].name, "_hold"}, bus.DiffV, held.diffv);
    end

    // A second start while running must be ignored entirely.
    applyStimulus(vecs[0], 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    driveVec(vecs[1]);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    finishOp("midrun_start", 5);
    @(posedge clk); #1;
    checkOutput("midrun_idle", VW'(bus.busy), VW'(0));

    // Asynchronous reset in the middle of an operation.
    applyStimulus(vecs[5], 1'b0);
    repeat (6) begin @(posedge clk); #1; end
    checkOutput("pre_rst_Overflw", VW'(bus.Overflw), VW'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_DiffV",   bus.DiffV, '0);
    checkOutput("midrst_Overflw", VW'(bus.Overflw), VW'(0));
    checkOutput("midrst_busy",    VW'(bus.busy), VW'(0));
    checkOutput("midrst_done",    VW'(bus.done), VW'(0));
    sb_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(vecs[4], 1'b0);
    finishOp("after_rst", 0);

    // Start held high through DONE gives a back-to-back second operation.
    @(posedge clk); #1;
    applyStimulus(vecs[7], 1'b1);
    driveVec(vecs[9]);
    sb_q.push_back(expectOf(vecs[9]));
    finishOp("b2b_first", 0);
    @(posedge clk); #1;
    checkOutput("b2b_busy",  VW'(bus.busy), VW'(1));
    checkOutput("b2b_done",  VW'(bus.done), VW'(0));
    checkOutput("b2b_clear", bus.DiffV, '0);
    bus.start = 1'b0;
    scramble();
    finishOp("b2b_second", 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
